// File: rtl/junction_sequencer.sv
`timescale 1ns/1ps
// Junction sequencer: debounces wheel encoders and sequences cross/turn/stop
// manoeuvres at a junction from tone-detect commands.
module junction_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned STRAIGHT_PULSES = 10,
  parameter int unsigned TURN_PULSES     = 20,
  parameter int unsigned BACK_PULSES     = 40,
  parameter int unsigned TIMEOUT_CYCLES  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       td_en,
  input  logic [2:0] td_dir,
  input  logic       shaft_pulse_l,
  input  logic       shaft_pulse_r,
  output logic [3:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] cnt_l,
  output logic [7:0] cnt_r
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] DIR_STRAIGHT = 3'b000;
  localparam logic [2:0] DIR_LEFT     = 3'b001;
  localparam logic [2:0] DIR_BACK     = 3'b011;
  localparam logic [2:0] DIR_STOP     = 3'b100;

  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_LEFT  = 4'b0111;
  localparam logic [3:0] CMD_RIGHT = 4'b1011;
  localparam logic [3:0] CMD_STOP  = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CROSS   = 3'd1,
    S_TURN    = 3'd2,
    S_STOPPED = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        dir_q, dir_d;
  logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]        filt_q, filt_d, rise_c;
  logic [DB_W-1:0]   db_cnt_q [2];
  logic [DB_W-1:0]   db_cnt_d [2];
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic [7:0]        outer_c, target_c;

  // Two-stage synchroniser and per-wheel debounce; rise_c flags a filtered 0->1.
  always_comb begin
    sync1_d = {shaft_pulse_r, shaft_pulse_l};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    rise_c  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = sync2_q[i];
          rise_c[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Outer wheel and pulse target for the pivot selected by the latched direction.
  always_comb begin
    outer_c  = (dir_q == DIR_LEFT) ? cnt_r_q : cnt_l_q;
    target_c = (dir_q == DIR_BACK) ? 8'(BACK_PULSES) : 8'(TURN_PULSES);
  end

  // Next state, saturating pulse counters, timeout and registered output values.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    cnt_l_d = (rise_c[0] && cnt_l_q != 8'hFF) ? cnt_l_q + 8'd1 : cnt_l_q;
    cnt_r_d = (rise_c[1] && cnt_r_q != 8'hFF) ? cnt_r_q + 8'd1 : cnt_r_q;
    tmo_d   = (state_q == S_CROSS || state_q == S_TURN) ? tmo_q + TMO_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (td_en) begin
          if (td_dir <= DIR_BACK) begin
            dir_d   = td_dir;
            state_d = S_CROSS;
          end else if (td_dir == DIR_STOP) begin
            state_d = S_STOPPED;
          end
        end
      end
      S_CROSS: begin
        if (cnt_l_q >= 8'(STRAIGHT_PULSES) && cnt_r_q >= 8'(STRAIGHT_PULSES)) begin
          if (dir_q == DIR_STRAIGHT) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_TURN;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_TURN: begin
        if (outer_c >= target_c) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_STOPPED: begin
        if (td_en && td_dir <= DIR_BACK) begin
          dir_d   = td_dir;
          state_d = S_CROSS;
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase

    // Every state entry restarts pulse and timeout counting; an edge in that cycle is lost.
    if (state_d != state_q) begin
      cnt_l_d = '0;
      cnt_r_d = '0;
      tmo_d   = '0;
      if (state_d == S_STOPPED) done_d = 1'b1;
    end

    case (state_d)
      S_TURN:             cmd_d = (dir_d == DIR_LEFT) ? CMD_LEFT : CMD_RIGHT;
      S_STOPPED, S_FAULT: cmd_d = CMD_STOP;
      default:            cmd_d = CMD_NONE;
    endcase
    busy_d  = (state_d == S_CROSS) || (state_d == S_TURN) || (state_d == S_STOPPED);
    fault_d = (state_d == S_FAULT);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      tmo_q       <= '0;
      cnt_l_q     <= '0;
      cnt_r_q     <= '0;
      cmd_q       <= CMD_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      tmo_q       <= tmo_d;
      cnt_l_q     <= cnt_l_d;
      cnt_r_q     <= cnt_r_d;
      cmd_q       <= cmd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign cmd   = cmd_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign fault = fault_q;
  assign cnt_l = cnt_l_q;
  assign cnt_r = cnt_r_q;

endmodule

// File: tb/tb_junction_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for junction_sequencer with small parameters.
module tb_junction_sequencer;

  localparam int unsigned DB = 4;
  localparam int unsigned SP = 2;
  localparam int unsigned TP = 3;
  localparam int unsigned BP = 6;
  localparam int unsigned TO = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       td_en = 1'b0;
  logic [2:0] td_dir = 3'b000;
  logic       spl = 1'b0;
  logic       spr = 1'b0;
  logic [3:0] cmd;
  logic       busy, done, fault;
  logic [7:0] cnt_l, cnt_r;

  int checks = 0;
  int errors = 0;

  logic [3:0] obs_cmd[$];
  logic [3:0] exp_cmd[$];
  logic [3:0] last_cmd = 4'b0000;
  int         done_cnt = 0;
  int         done_long = 0;
  logic       prev_done = 1'b0;

  junction_sequencer #(
    .DEBOUNCE_CYCLES(DB), .STRAIGHT_PULSES(SP), .TURN_PULSES(TP),
    .BACK_PULSES(BP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .td_en(td_en), .td_dir(td_dir),
    .shaft_pulse_l(spl), .shaft_pulse_r(spr),
    .cmd(cmd), .busy(busy), .done(done), .fault(fault),
    .cnt_l(cnt_l), .cnt_r(cnt_r)
  );

  always #10 clk = ~clk;

  // Monitor: records every cmd change and every done pulse (and over-long ones).
  always @(negedge clk) begin
    if (cmd !== last_cmd) begin
      obs_cmd.push_back(cmd);
      last_cmd = cmd;
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (prev_done === 1'b1) done_long = done_long + 1;
    end
    prev_done = done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle td_en strobe; returns at the negedge after the DUT sampled it.
  task automatic issue(input logic [2:0] d);
    td_en  = 1'b1;
    td_dir = d;
    @(negedge clk);
    td_en  = 1'b0;
    td_dir = 3'b000;
  endtask

  task automatic pulse(input logic l, input logic r, input int hi, input int lo);
    spl = l;
    spr = r;
    cyc(hi);
    spl = 1'b0;
    spr = 1'b0;
    cyc(lo);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    checks++;
    if (cmd !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%b busy=%b done=%b fault=%b, expected 0000 0 0 0", cmd, busy, done, fault);
    end
    checks++;
    if (cnt_l !== 8'd0 || cnt_r !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d, expected 0/0", cnt_l, cnt_r);
    end
  endtask

  task automatic test_left();
    int base, d0, dl0;
    cyc(2);
    base = obs_cmd.size(); d0 = done_cnt; dl0 = done_long;
    exp_cmd.push_back(4'b0111);
    exp_cmd.push_back(4'b0000);
    issue(3'b001);
    checks++;
    if (cmd !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL left_cross: got cmd=%b busy=%b, expected 0000 1", cmd, busy);
    end
    repeat (2) pulse(1'b1, 1'b1, 8, 8);
    checks++;
    if (cmd !== 4'b0111 || cnt_l !== 8'd0 || done_cnt != d0) begin
      errors++;
      $display("FAIL left_turn_entry: got cmd=%b cnt_l=%0d dones=%0d, expected 0111 0 0", cmd, cnt_l, done_cnt - d0);
    end
    repeat (2) pulse(1'b0, 1'b1, 8, 8);
    checks++;
    if (cnt_r !== 8'd2 || cmd !== 4'b0111) begin
      errors++;
      $display("FAIL left_turn_partial: got cnt_r=%0d cmd=%b, expected 2 0111", cnt_r, cmd);
    end
    pulse(1'b0, 1'b1, 8, 8);
    checks++;
    if (done_cnt - d0 != 1 || done_long != dl0) begin
      errors++;
      $display("FAIL left_done: got %0d pulses (%0d long), expected 1 (0)", done_cnt - d0, done_long - dl0);
    end
    checks++;
    if (cmd !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL left_idle: got cmd=%b busy=%b, expected 0000 0", cmd, busy);
    end
    for (int i = 0; i < 2; i++) begin
      logic [3:0] e;
      e = exp_cmd.pop_front();
      checks++;
      if (base + i >= obs_cmd.size()) begin
        errors++;
        $display("FAIL left_cmd_seq[%0d]: got none, expected %b", i, e);
      end else if (obs_cmd[base + i] !== e) begin
        errors++;
        $display("FAIL left_cmd_seq[%0d]: got %b, expected %b", i, obs_cmd[base + i], e);
      end
    end
  endtask

  task automatic test_debounce();
    int d0;
    cyc(2);
    d0 = done_cnt;
    issue(3'b000);
    repeat (10) pulse(1'b0, 1'b1, 3, 6);
    checks++;
    if (cnt_r !== 8'd0) begin
      errors++;
      $display("FAIL debounce_glitch: got cnt_r=%0d, expected 0", cnt_r);
    end
    pulse(1'b0, 1'b1, 6, 8);
    checks++;
    if (cnt_r !== 8'd1 || cnt_l !== 8'd0) begin
      errors++;
      $display("FAIL debounce_pulse: got cnt_r=%0d cnt_l=%0d, expected 1 0", cnt_r, cnt_l);
    end
    repeat (2) pulse(1'b1, 1'b0, 8, 8);
    checks++;
    if (busy !== 1'b1 || cnt_l !== 8'd2 || done_cnt != d0) begin
      errors++;
      $display("FAIL straight_wait: got busy=%b cnt_l=%0d dones=%0d, expected 1 2 0", busy, cnt_l, done_cnt - d0);
    end
    pulse(1'b0, 1'b1, 8, 8);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || cmd !== 4'b0000) begin
      errors++;
      $display("FAIL straight_done: got dones=%0d busy=%b cmd=%b, expected 1 0 0000", done_cnt - d0, busy, cmd);
    end
  endtask

  task automatic test_stop();
    int base, d0;
    cyc(2);
    base = obs_cmd.size(); d0 = done_cnt;
    exp_cmd.push_back(4'b1100);
    exp_cmd.push_back(4'b0000);
    issue(3'b100);
    checks++;
    if (cmd !== 4'b1100 || busy !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL stop_entry: got cmd=%b busy=%b done=%b, expected 1100 1 1", cmd, busy, done);
    end
    cyc(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL stop_done_width: got done=%b, expected 0", done);
    end
    issue(3'b100);
    cyc(1);
    checks++;
    if (cmd !== 4'b1100 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_reissue: got cmd=%b busy=%b done=%b, expected 1100 1 0", cmd, busy, done);
    end
    issue(3'b000);
    checks++;
    if (cmd !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_resume: got cmd=%b busy=%b, expected 0000 1", cmd, busy);
    end
    repeat (2) pulse(1'b1, 1'b1, 8, 8);
    checks++;
    if (done_cnt - d0 != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_complete: got dones=%0d busy=%b, expected 2 0", done_cnt - d0, busy);
    end
    for (int i = 0; i < 2; i++) begin
      logic [3:0] e;
      e = exp_cmd.pop_front();
      checks++;
      if (base + i >= obs_cmd.size()) begin
        errors++;
        $display("FAIL stop_cmd_seq[%0d]: got none, expected %b", i, e);
      end else if (obs_cmd[base + i] !== e) begin
        errors++;
        $display("FAIL stop_cmd_seq[%0d]: got %b, expected %b", i, obs_cmd[base + i], e);
      end
    end
  endtask

  task automatic test_back();
    int d0;
    cyc(2);
    d0 = done_cnt;
    issue(3'b011);
    repeat (2) pulse(1'b1, 1'b1, 8, 8);
    repeat (BP - 1) pulse(1'b1, 1'b0, 8, 8);
    checks++;
    if (cmd !== 4'b1011 || cnt_l !== 8'(BP - 1) || done_cnt != d0) begin
      errors++;
      $display("FAIL back_partial: got cmd=%b cnt_l=%0d dones=%0d, expected 1011 %0d 0", cmd, cnt_l, done_cnt - d0, BP - 1);
    end
    pulse(1'b0, 1'b1, 8, 8);
    checks++;
    if (busy !== 1'b1 || cnt_r !== 8'd1) begin
      errors++;
      $display("FAIL back_inner_ignored: got busy=%b cnt_r=%0d, expected 1 1", busy, cnt_r);
    end
    pulse(1'b1, 1'b0, 8, 8);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || cmd !== 4'b0000) begin
      errors++;
      $display("FAIL back_done: got dones=%0d busy=%b cmd=%b, expected 1 0 0000", done_cnt - d0, busy, cmd);
    end
  endtask

  task automatic test_timeout();
    int d0, n;
    cyc(2);
    d0 = done_cnt;
    n  = 0;
    issue(3'b011);
    while (fault !== 1'b1 && n < TO + 100) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d, expected %0d", n, TO);
    end
    checks++;
    if (cmd !== 4'b1100 || busy !== 1'b0 || done !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL fault_outputs: got cmd=%b busy=%b done=%b dones=%0d, expected 1100 0 0 0", cmd, busy, done, done_cnt - d0);
    end
    issue(3'b000);
    issue(3'b100);
    cyc(1);
    checks++;
    if (fault !== 1'b1 || cmd !== 4'b1100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: got fault=%b cmd=%b busy=%b, expected 1 1100 0", fault, cmd, busy);
    end
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    checks++;
    if (fault !== 1'b0 || cmd !== 4'b0000 || busy !== 1'b0 || cnt_l !== 8'd0 || cnt_r !== 8'd0) begin
      errors++;
      $display("FAIL fault_reset: got fault=%b cmd=%b busy=%b cnt=%0d/%0d, expected 0 0000 0 0/0", fault, cmd, busy, cnt_l, cnt_r);
    end
  endtask

  task automatic test_reset_turn();
    int d0;
    cyc(2);
    issue(3'b010);
    repeat (2) pulse(1'b1, 1'b1, 8, 8);
    repeat (2) pulse(1'b1, 1'b0, 8, 8);
    checks++;
    if (cmd !== 4'b1011 || cnt_l !== 8'd2) begin
      errors++;
      $display("FAIL right_turn_partial: got cmd=%b cnt_l=%0d, expected 1011 2", cmd, cnt_l);
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    cyc(1);
    checks++;
    if (cmd !== 4'b0000 || cnt_l !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL turn_reset: got cmd=%b cnt_l=%0d busy=%b done=%b, expected 0000 0 0 0", cmd, cnt_l, busy, done);
    end
    rst_n = 1'b1;
    issue(3'b000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_cmd_after_reset: got busy=%b, expected 1", busy);
    end
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    issue(3'b111);
    cyc(4);
    checks++;
    if (busy !== 1'b0 || cmd !== 4'b0000 || done_cnt != d0) begin
      errors++;
      $display("FAIL invalid_ignored: got busy=%b cmd=%b dones=%0d, expected 0 0000 0", busy, cmd, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_debounce();
    test_stop();
    test_back();
    test_timeout();
    test_reset_turn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
